// File: rtl/nibbler_pkg.sv
// Shared types and constants for the Nibbler control unit.
// Optional HALT opcode is enabled by defining NIBBLER_HALT_EN.
package nibbler_pkg;

    localparam int PC_W = 12;  // program counter and data address width
    localparam int OP_W = 4;   // opcode width (upper nibble of first byte)

    typedef enum logic [OP_W-1:0] {
        OP_ADDI = 4'h0, OP_ADDM = 4'h1, OP_SUBI = 4'h2, OP_SUBM = 4'h3,
        OP_NORI = 4'h4, OP_NORM = 4'h5, OP_LIT  = 4'h6, OP_LD   = 4'h7,
        OP_ST   = 4'h8, OP_IN   = 4'h9, OP_OUT  = 4'hA, OP_JMP  = 4'hB,
        OP_JZ   = 4'hC, OP_JC   = 4'hD, OP_CMPI = 4'hE, OP_NOP  = 4'hF
    } opcode_e;

    // ALU mode codes as {notCarryIn, S[2:0]}
    localparam logic [3:0] ALU_ADD      = 4'b1011;
    localparam logic [3:0] ALU_SUB      = 4'b0001;
    localparam logic [3:0] ALU_NOR      = 4'b1100;
    localparam logic [3:0] ALU_PASS_BUS = 4'b1010;
    localparam logic [3:0] ALU_PASS_A   = 4'b1000;

    typedef enum logic [1:0] {
        BUS_IMM  = 2'd0,
        BUS_RAM  = 2'd1,
        BUS_IN   = 2'd2,
        BUS_NONE = 2'd3
    } bus_sel_e;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_OPERAND = 2'd1,
        ST_EXECUTE = 2'd2
    } state_e;

    // Opcodes whose address byte follows in the next ROM location
    function automatic logic is_two_byte(input logic [OP_W-1:0] op);
        case (op)
            OP_ADDM, OP_SUBM, OP_NORM, OP_LD,
            OP_ST, OP_JMP, OP_JZ, OP_JC: is_two_byte = 1'b1;
            default:                     is_two_byte = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/nibbler_control_unit_decoder.sv
// Combinational opcode decoder: produces strobes, ALU mode, bus source and
// jump decision. Everything stays idle outside an enabled EXECUTE cycle.
module nibbler_decoder
    import nibbler_pkg::*;
(
    input  logic       enable,
    input  logic [1:0] state,
    input  logic [7:0] ir,
    input  logic       notC_q,
    input  logic       notZ_q,
    output logic [3:0] alu_mode,
    output logic [1:0] bus_sel,
    output logic       load_A,
    output logic       load_out,
    output logic       mem_we,
    output logic       flag_we,
    output logic       jump_taken
);

    opcode_e op;
    assign op = opcode_e'(ir[7:4]);

    // Decode the latched instruction into this cycle's control word
    always_comb begin
        alu_mode   = ALU_PASS_A;
        bus_sel    = BUS_NONE;
        load_A     = 1'b0;
        load_out   = 1'b0;
        mem_we     = 1'b0;
        flag_we    = 1'b0;
        jump_taken = 1'b0;
        if (enable && state == ST_EXECUTE) begin
            case (op)
                OP_ADDI: begin alu_mode = ALU_ADD; bus_sel = BUS_IMM; load_A = 1'b1; flag_we = 1'b1; end
                OP_ADDM: begin alu_mode = ALU_ADD; bus_sel = BUS_RAM; load_A = 1'b1; flag_we = 1'b1; end
                OP_SUBI: begin alu_mode = ALU_SUB; bus_sel = BUS_IMM; load_A = 1'b1; flag_we = 1'b1; end
                OP_SUBM: begin alu_mode = ALU_SUB; bus_sel = BUS_RAM; load_A = 1'b1; flag_we = 1'b1; end
                OP_NORI: begin alu_mode = ALU_NOR; bus_sel = BUS_IMM; load_A = 1'b1; flag_we = 1'b1; end
                OP_NORM: begin alu_mode = ALU_NOR; bus_sel = BUS_RAM; load_A = 1'b1; flag_we = 1'b1; end
                OP_LIT:  begin alu_mode = ALU_PASS_BUS; bus_sel = BUS_IMM; load_A = 1'b1; end
                OP_LD:   begin alu_mode = ALU_PASS_BUS; bus_sel = BUS_RAM; load_A = 1'b1; end
                OP_IN:   begin alu_mode = ALU_PASS_BUS; bus_sel = BUS_IN;  load_A = 1'b1; end
                OP_ST:   mem_we   = 1'b1;
                OP_OUT:  load_out = 1'b1;
                OP_JMP:  jump_taken = 1'b1;
                OP_JZ:   jump_taken = ~notZ_q;
                OP_JC:   jump_taken = ~notC_q;
                // Compare is a subtract whose result is discarded
                OP_CMPI: begin alu_mode = ALU_SUB; bus_sel = BUS_IMM; flag_we = 1'b1; end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/nibbler_control_unit.sv
// Nibbler instruction sequencer: fetch FSM, PC, IR/operand and flags.
// Define NIBBLER_HALT_EN to make opcode 0xFF a sticky HALT.
module nibbler_control_unit
    import nibbler_pkg::*;
(
    input  logic            clk,
    input  logic            notReset,
    input  logic [7:0]      rom_data,
    input  logic            alu_notC,
    input  logic            alu_notZ,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] data_addr,
    output logic [3:0]      imm,
    output logic [1:0]      bus_sel,
    output logic [2:0]      alu_S,
    output logic            alu_notCarryIn,
    output logic            load_A,
    output logic            load_out,
    output logic            mem_we,
    output logic            notC_q,
    output logic            notZ_q,
    output logic            halted,
    output logic [1:0]      state_dbg
);

    state_e          state, state_next;
    logic [PC_W-1:0] pc_q;
    logic [7:0]      ir;
    logic [7:0]      operand;
    logic [3:0]      alu_mode;
    logic            flag_we;
    logic            jump_taken;
    logic            halted_q;

    // Strobes are suppressed while reset is asserted or the core is halted
    nibbler_decoder u_decoder (
        .enable     (notReset & ~halted_q),
        .state      (state),
        .ir         (ir),
        .notC_q     (notC_q),
        .notZ_q     (notZ_q),
        .alu_mode   (alu_mode),
        .bus_sel    (bus_sel),
        .load_A     (load_A),
        .load_out   (load_out),
        .mem_we     (mem_we),
        .flag_we    (flag_we),
        .jump_taken (jump_taken)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!notReset) state <= ST_FETCH;
        else           state <= state_next;
    end

    // Next-state: two-byte opcodes detour through OPERAND; halt parks in FETCH
    always_comb begin
        state_next = state;
        if (!halted_q) begin
            case (state)
                ST_FETCH:   state_next = is_two_byte(rom_data[7:4]) ? ST_OPERAND : ST_EXECUTE;
                ST_OPERAND: state_next = ST_EXECUTE;
                ST_EXECUTE: state_next = ST_FETCH;
                default:    state_next = ST_FETCH;
            endcase
        end
    end

    // PC, instruction, operand and flag registers; PC wraps modulo 2^PC_W
    always_ff @(posedge clk) begin
        if (!notReset) begin
            pc_q    <= '0;
            ir      <= 8'hF0;
            operand <= 8'h00;
            notC_q  <= 1'b1;
            notZ_q  <= 1'b1;
        end else if (!halted_q) begin
            case (state)
                ST_FETCH: begin
                    ir   <= rom_data;
                    pc_q <= pc_q + PC_W'(1);
                end
                ST_OPERAND: begin
                    operand <= rom_data;
                    pc_q    <= pc_q + PC_W'(1);
                end
                ST_EXECUTE: begin
                    if (jump_taken) pc_q <= {ir[3:0], operand};
                    if (flag_we) begin
                        notC_q <= alu_notC;
                        notZ_q <= alu_notZ;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NIBBLER_HALT_EN
    // Sticky halt on opcode 0xFF; only reset clears it
    always_ff @(posedge clk) begin
        if (!notReset)
            halted_q <= 1'b0;
        else if (!halted_q && state == ST_EXECUTE && ir == 8'hFF)
            halted_q <= 1'b1;
    end
`else
    assign halted_q = 1'b0;
`endif

    assign pc             = pc_q;
    assign data_addr      = {ir[3:0], operand};
    assign imm            = ir[3:0];
    assign alu_notCarryIn = alu_mode[3];
    assign alu_S          = alu_mode[2:0];
    assign halted         = halted_q;
    assign state_dbg      = state;

endmodule
